// File: rtl/mgmt_uart_pkg.sv
// Shared definitions for the management UART (receiver now, transmitter later).
package mgmt_uart_pkg;

    // 25 MHz board clock / 115200 baud
    localparam int unsigned UART_CLKS_PER_BIT = 217;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module sync_bit #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both take the reset value so no spurious edge is seen at reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mgmt_uart_rx.sv
// Management UART receiver: 8 data bits LSB-first, one stop bit, mid-bit sampling.
// Optional even parity bit is compiled in with `define MGMT_UART_RX_PARITY_EN.
module mgmt_uart_rx
    import mgmt_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_en,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    logic           rx_s;
    uart_rx_state_t state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;

    sync_bit #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef MGMT_UART_RX_PARITY_EN
    logic par_bad;
    logic parity_err_r;

    assign parity_err = parity_err_r;

    // Parity bit is checked in its own state; the result is held until the stop bit decides the outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad      <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= 1'b0;
            if (state == ST_PARITY && cnt == BIT_M1) begin
                par_bad <= rx_s ^ (^shift);
            end
            if (state == ST_STOP && cnt == BIT_M1) begin
                parity_err_r <= par_bad;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Frame FSM: start-bit qualification, bit-time counting, data shift and stop-bit outcome strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_en     <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_en     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef MGMT_UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef MGMT_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
`ifdef MGMT_UART_RX_PARITY_EN
                            if (!par_bad) begin
                                rx_en   <= 1'b1;
                                rx_data <= shift;
                            end
`else
                            rx_en   <= 1'b1;
                            rx_data <= shift;
`endif
                            state <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
